// File: rtl/cache_line_filler_pkg.sv
// cache_pkg: shared definitions for the data cache miss engine.
//
// Holds the address field widths, the filler FSM state encoding and small
// helpers that slice a byte address into tag / line index / column index.
// Address layout: {tag, line_ix, column_ix, 2'b00}.
package cache_pkg;

    localparam int ZEROS_BITWIDTH     = 2;
    localparam int COLUMN_IX_BITWIDTH = 2;
    localparam int LINE_IX_BITWIDTH   = 8;
    localparam int TAG_BITWIDTH       = 32 - LINE_IX_BITWIDTH - COLUMN_IX_BITWIDTH - ZEROS_BITWIDTH;

    typedef enum logic [2:0] {
        IDLE,
        WB_CMD,
        WB_READ,
        WB_DATA,
        RD_CMD,
        RD_DATA,
        DONE
    } state_t;

    function automatic logic [TAG_BITWIDTH-1:0] tag_of(input logic [31:0] address);
        return address[31 -: TAG_BITWIDTH];
    endfunction

    function automatic logic [LINE_IX_BITWIDTH-1:0] line_ix_of(input logic [31:0] address);
        return address[ZEROS_BITWIDTH + COLUMN_IX_BITWIDTH +: LINE_IX_BITWIDTH];
    endfunction

    function automatic logic [COLUMN_IX_BITWIDTH-1:0] column_ix_of(input logic [31:0] address);
        return address[ZEROS_BITWIDTH +: COLUMN_IX_BITWIDTH];
    endfunction

endpackage

// File: rtl/cache_line_filler_if.sv
// cache_line_filler_if: bundle of every bus the line filler touches.
//
// Groups three sides:
//   request side : req_valid/req_ready/req_address, busy, done
//   cache side   : cache_address/cache_data/cache_write_enable, cache_rdata,
//                  victim_tag, victim_dirty
//   memory side  : mem_cmd_* burst command, mem_rdata read stream,
//                  mem_wdata writeback stream
// Modport master is the filler itself; modport slave is everything around it
// (CPU, cache arrays, PSRAM controller).
interface cache_line_filler_if;
    import cache_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic [31:0]             req_address;
    logic                    busy;
    logic                    done;

    logic [31:0]             cache_address;
    logic [31:0]             cache_data;
    logic                    cache_write_enable;
    logic [31:0]             cache_rdata;
    logic [TAG_BITWIDTH-1:0] victim_tag;
    logic                    victim_dirty;

    logic                    mem_cmd_valid;
    logic                    mem_cmd_ready;
    logic [31:0]             mem_cmd_address;
    logic                    mem_cmd_write;
    logic [31:0]             mem_rdata;
    logic                    mem_rdata_valid;
    logic [31:0]             mem_wdata;
    logic                    mem_wdata_valid;
    logic                    mem_wdata_ready;

    modport master (
        input  req_valid, req_address,
        output req_ready, busy, done,
        output cache_address, cache_data, cache_write_enable,
        input  cache_rdata, victim_tag, victim_dirty,
        output mem_cmd_valid, mem_cmd_address, mem_cmd_write,
        input  mem_cmd_ready, mem_rdata, mem_rdata_valid,
        output mem_wdata, mem_wdata_valid,
        input  mem_wdata_ready
    );

    modport slave (
        output req_valid, req_address,
        input  req_ready, busy, done,
        input  cache_address, cache_data, cache_write_enable,
        output cache_rdata, victim_tag, victim_dirty,
        input  mem_cmd_valid, mem_cmd_address, mem_cmd_write,
        output mem_cmd_ready, mem_rdata, mem_rdata_valid,
        input  mem_wdata, mem_wdata_valid,
        output mem_wdata_ready
    );

endinterface

// File: rtl/cache_line_filler.sv
// cache_line_filler: miss engine for the direct-mapped 4-column data cache.
//
// On an accepted miss request it issues a burst read for the whole line to
// the PSRAM controller and streams each returned word into the cache write
// port, column 0 first. busy stays high until the line is consistent and done
// pulses for one cycle at the end.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, returns to IDLE and drops any burst
//   bus  - cache_line_filler_if.master (request, cache and memory sides)
//
// Build option: define CACHE_LINE_FILLER_WRITEBACK_EN to write a dirty victim
// line back to memory (WB_CMD/WB_READ/WB_DATA) before the fill. Without it
// victim_dirty/victim_tag are ignored and mem_cmd_write/mem_wdata_valid are 0.
module cache_line_filler #(
    parameter int LINE_IX_BITWIDTH   = cache_pkg::LINE_IX_BITWIDTH,
    parameter int COLUMN_IX_BITWIDTH = cache_pkg::COLUMN_IX_BITWIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    cache_line_filler_if.master    bus
);
    import cache_pkg::*;

    localparam int OFFSET_BITWIDTH = COLUMN_IX_BITWIDTH + ZEROS_BITWIDTH;
    localparam int TAG_W           = 32 - LINE_IX_BITWIDTH - OFFSET_BITWIDTH;
    localparam int LINE_BITWIDTH   = TAG_W + LINE_IX_BITWIDTH;
    localparam logic [COLUMN_IX_BITWIDTH-1:0] COUNT_ONE  = 1;
    localparam logic [COLUMN_IX_BITWIDTH-1:0] COUNT_LAST = '1;

    state_t                        state;
    state_t                        state_next;
    logic [COLUMN_IX_BITWIDTH-1:0] count;
    logic [COLUMN_IX_BITWIDTH-1:0] count_next;
    logic [LINE_BITWIDTH-1:0]      line_q;
    logic                          accept;
    logic [31:0]                   word_address;

    logic unused_low_bits;
    assign unused_low_bits = ^bus.req_address[OFFSET_BITWIDTH-1:0];

`ifdef CACHE_LINE_FILLER_WRITEBACK_EN
    // Victim tag is captured with the request so the writeback command
    // address cannot move while the controller backpressures it.
    logic [TAG_W-1:0] victim_tag_q;
`else
    logic unused_writeback_inputs;
    assign unused_writeback_inputs = ^{bus.victim_dirty, bus.victim_tag,
                                       bus.mem_wdata_ready, bus.cache_rdata};
`endif

    // Both fill and writeback walk the same line, so one address suffices.
    assign word_address = {line_q, count, {ZEROS_BITWIDTH{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            line_q <= '0;
`ifdef CACHE_LINE_FILLER_WRITEBACK_EN
            victim_tag_q <= '0;
`endif
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) begin
                line_q <= bus.req_address[31:OFFSET_BITWIDTH];
`ifdef CACHE_LINE_FILLER_WRITEBACK_EN
                victim_tag_q <= bus.victim_tag;
`endif
            end
        end
    end

    always_comb begin
        state_next             = state;
        count_next             = count;
        accept                 = 1'b0;
        bus.req_ready          = 1'b0;
        bus.busy               = (state != IDLE);
        bus.done               = 1'b0;
        bus.cache_address      = '0;
        bus.cache_data         = '0;
        bus.cache_write_enable = 1'b0;
        bus.mem_cmd_valid      = 1'b0;
        bus.mem_cmd_address    = '0;
        bus.mem_cmd_write      = 1'b0;
        bus.mem_wdata          = '0;
        bus.mem_wdata_valid    = 1'b0;

        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
`ifdef CACHE_LINE_FILLER_WRITEBACK_EN
                    state_next = bus.victim_dirty ? WB_CMD : RD_CMD;
`else
                    state_next = RD_CMD;
`endif
                end
            end

`ifdef CACHE_LINE_FILLER_WRITEBACK_EN
            WB_CMD: begin
                bus.mem_cmd_valid   = 1'b1;
                bus.mem_cmd_write   = 1'b1;
                bus.mem_cmd_address = {victim_tag_q, line_q[LINE_IX_BITWIDTH-1:0],
                                       {OFFSET_BITWIDTH{1'b0}}};
                if (bus.mem_cmd_ready) begin
                    state_next = WB_READ;
                    count_next = '0;
                end
            end

            // The cache array has one cycle of read latency: present the
            // address here, the word appears on cache_rdata in WB_DATA.
            WB_READ: begin
                bus.cache_address = word_address;
                state_next        = WB_DATA;
            end

            WB_DATA: begin
                bus.cache_address   = word_address;
                bus.mem_wdata       = bus.cache_rdata;
                bus.mem_wdata_valid = 1'b1;
                if (bus.mem_wdata_ready) begin
                    if (count == COUNT_LAST) begin
                        state_next = RD_CMD;
                        count_next = '0;
                    end else begin
                        state_next = WB_READ;
                        count_next = count + COUNT_ONE;
                    end
                end
            end
`endif

            RD_CMD: begin
                bus.mem_cmd_valid   = 1'b1;
                bus.mem_cmd_address = {line_q, {OFFSET_BITWIDTH{1'b0}}};
                if (bus.mem_cmd_ready) begin
                    state_next = RD_DATA;
                    count_next = '0;
                end
            end

            // Read data has no backpressure, so each valid word is written
            // into the cache in the very cycle it arrives.
            RD_DATA: begin
                bus.cache_address = word_address;
                if (bus.mem_rdata_valid) begin
                    bus.cache_write_enable = 1'b1;
                    bus.cache_data         = bus.mem_rdata;
                    count_next             = count + COUNT_ONE;
                    if (count == COUNT_LAST) begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_line_filler.sv
// tb_cache_line_filler: directed self-checking bench for cache_line_filler.
//
// Drives the slave side of cache_line_filler_if cycle by cycle with
// hand-computed expectations: reset state, a plain fill, gapped read data,
// command backpressure, reset in mid-burst and requests while busy. With
// CACHE_LINE_FILLER_WRITEBACK_EN defined it also covers a dirty-victim
// writeback ahead of the fill.
module tb_cache_line_filler;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cmd_count   = 0;
    int   cmd_before;
    logic [31:0] wr_log[$];

    always #5 clk = ~clk;

    cache_line_filler_if bus();

    cache_line_filler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Record every committed cache write and memory command handshake.
    always @(posedge clk) begin
        if (!rst && bus.cache_write_enable) wr_log.push_back(bus.cache_address);
        if (!rst && bus.mem_cmd_valid && bus.mem_cmd_ready) cmd_count++;
    end

`ifdef CACHE_LINE_FILLER_WRITEBACK_EN
    // Cache array stand-in: one-cycle read latency, contents derived from
    // the address so writeback words are recognisable.
    always @(posedge clk) bus.cache_rdata <= 32'hC000_0000 | bus.cache_address;
`endif

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] ra, input logic cr,
                                 input logic dv, input logic [31:0] dd);
        bus.req_valid       = rv;
        bus.req_address     = ra;
        bus.mem_cmd_ready   = cr;
        bus.mem_rdata_valid = dv;
        bus.mem_rdata       = dd;
        #1;
    endtask

    task automatic issueRequest(input logic [31:0] addr);
        applyStimulus(1'b1, addr, 1'b0, 1'b0, 32'h0);
        checkOutput("req_ready_idle", bus.req_ready, 1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("busy_after_req", bus.busy, 1);
    endtask

    task automatic acceptCmd(input logic [31:0] exp_addr, input logic exp_write);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("cmd_valid", bus.mem_cmd_valid, 1);
        checkOutput("cmd_address", bus.mem_cmd_address, exp_addr);
        checkOutput("cmd_write", bus.mem_cmd_write, exp_write);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic driveBurst(input logic [15:0] pattern, input int len,
                              input logic [31:0] line_addr, input logic [31:0] data_base);
        int k;
        k = 0;
        for (int i = 0; i < len; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, pattern[i],
                          pattern[i] ? data_base + k : 32'hDEAD_BEEF);
            checkOutput("cache_we", bus.cache_write_enable, pattern[i]);
            if (pattern[i]) begin
                checkOutput("cache_address", bus.cache_address, line_addr + 4 * k);
                checkOutput("cache_data", bus.cache_data, data_base + k);
                k++;
            end
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic checkDone();
        checkOutput("done_pulse", bus.done, 1);
        checkOutput("busy_in_done", bus.busy, 1);
        checkOutput("req_ready_in_done", bus.req_ready, 0);
        tick();
        checkOutput("done_cleared", bus.done, 0);
        checkOutput("busy_cleared", bus.busy, 0);
        checkOutput("req_ready_back", bus.req_ready, 1);
    endtask

    initial begin
        rst                 = 1'b1;
        bus.req_valid       = 1'b0;
        bus.req_address     = 32'h0;
        bus.mem_cmd_ready   = 1'b0;
        bus.mem_rdata       = 32'h0;
        bus.mem_rdata_valid = 1'b0;
        bus.mem_wdata_ready = 1'b0;
        bus.victim_tag      = '0;
        bus.victim_dirty    = 1'b0;
`ifndef CACHE_LINE_FILLER_WRITEBACK_EN
        bus.cache_rdata     = 32'h0;
`endif
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset state");
        checkOutput("rst_req_ready", bus.req_ready, 1);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_cmd_valid", bus.mem_cmd_valid, 0);
        checkOutput("rst_cmd_write", bus.mem_cmd_write, 0);
        checkOutput("rst_cache_we", bus.cache_write_enable, 0);
        checkOutput("rst_cache_address", bus.cache_address, 0);
        checkOutput("rst_wdata_valid", bus.mem_wdata_valid, 0);
        rst = 1'b0;

        $display("[TB] basic fill");
        issueRequest(32'h0000_1234);
        checkOutput("cmd_valid_wait", bus.mem_cmd_valid, 1);
        checkOutput("cmd_address_wait", bus.mem_cmd_address, 32'h0000_1230);
        tick();
        acceptCmd(32'h0000_1230, 1'b0);
        driveBurst(16'h000F, 4, 32'h0000_1230, 32'h0000_00A0);
        checkDone();

        $display("[TB] gapped read data");
        wr_log.delete();
        issueRequest(32'h0000_5678);
        acceptCmd(32'h0000_5670, 1'b0);
        driveBurst(16'h0059, 7, 32'h0000_5670, 32'h0000_00B0);
        applyStimulus(1'b1, 32'h0000_9990, 1'b0, 1'b0, 32'h0);
        checkOutput("done_gapped", bus.done, 1);
        checkOutput("no_accept_in_done", bus.req_ready, 0);
        tick();
        checkOutput("ready_after_done", bus.req_ready, 1);
        checkOutput("idle_after_done", bus.busy, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("stay_idle", bus.busy, 0);
        checkOutput("gapped_write_count", wr_log.size(), 4);
        for (int j = 0; j < 4; j++) begin
            checkOutput("gapped_write_order", wr_log[j], 32'h0000_5670 + 4 * j);
        end

        $display("[TB] command backpressure");
        wr_log.delete();
        issueRequest(32'h0000_ABC0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, (i == 3 || i == 7), 32'h0000_0077);
            checkOutput("bp_cmd_valid", bus.mem_cmd_valid, 1);
            checkOutput("bp_cmd_address", bus.mem_cmd_address, 32'h0000_ABC0);
            checkOutput("bp_cache_we", bus.cache_write_enable, 0);
            tick();
        end
        checkOutput("bp_no_writes", wr_log.size(), 0);
        acceptCmd(32'h0000_ABC0, 1'b0);
        driveBurst(16'h000F, 4, 32'h0000_ABC0, 32'h0000_00C0);
        checkDone();

        $display("[TB] reset mid-burst");
        issueRequest(32'h0000_2040);
        acceptCmd(32'h0000_2040, 1'b0);
        driveBurst(16'h0003, 2, 32'h0000_2040, 32'h0000_00D0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_req_ready", bus.req_ready, 1);
        checkOutput("mid_rst_busy", bus.busy, 0);
        checkOutput("mid_rst_cache_we", bus.cache_write_enable, 0);
        checkOutput("mid_rst_cmd_valid", bus.mem_cmd_valid, 0);
        checkOutput("mid_rst_done", bus.done, 0);
        issueRequest(32'h0000_3000);
        acceptCmd(32'h0000_3000, 1'b0);
        driveBurst(16'h000F, 4, 32'h0000_3000, 32'h0000_00E0);
        checkDone();

        $display("[TB] request while busy");
        cmd_before = cmd_count;
`ifndef CACHE_LINE_FILLER_WRITEBACK_EN
        bus.victim_dirty = 1'b1;
        bus.victim_tag   = 20'hFFFFF;
`endif
        issueRequest(32'h0000_4440);
        acceptCmd(32'h0000_4440, 1'b0);
        applyStimulus(1'b1, 32'h0000_8880, 1'b1, 1'b0, 32'h0);
        checkOutput("busy_req_ready", bus.req_ready, 0);
        checkOutput("busy_cmd_valid", bus.mem_cmd_valid, 0);
        tick();
        driveBurst(16'h000F, 4, 32'h0000_4440, 32'h0000_00F0);
        checkDone();
        bus.victim_dirty = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            checkOutput("idle_no_cmd", bus.mem_cmd_valid, 0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("single_cmd", cmd_count - cmd_before, 1);

`ifdef CACHE_LINE_FILLER_WRITEBACK_EN
        $display("[TB] dirty victim writeback");
        bus.victim_dirty = 1'b1;
        bus.victim_tag   = 20'h00012;
        issueRequest(32'h0000_0040);
        checkOutput("wb_cmd_valid", bus.mem_cmd_valid, 1);
        checkOutput("wb_cmd_write", bus.mem_cmd_write, 1);
        checkOutput("wb_cmd_address", bus.mem_cmd_address, 32'h0001_2040);
        tick();
        acceptCmd(32'h0001_2040, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("wb_read_address", bus.cache_address, 32'h0000_0040 + 4 * k);
            checkOutput("wb_read_wvalid", bus.mem_wdata_valid, 0);
            checkOutput("wb_read_cache_we", bus.cache_write_enable, 0);
            tick();
            if (k == 0) begin
                bus.mem_wdata_ready = 1'b0;
                #1;
                checkOutput("wb_stall_wvalid", bus.mem_wdata_valid, 1);
                checkOutput("wb_stall_wdata", bus.mem_wdata, 32'hC000_0040);
                tick();
            end
            bus.mem_wdata_ready = 1'b1;
            #1;
            checkOutput("wb_wvalid", bus.mem_wdata_valid, 1);
            checkOutput("wb_wdata", bus.mem_wdata, 32'hC000_0040 + 4 * k);
            checkOutput("wb_data_cache_we", bus.cache_write_enable, 0);
            tick();
            bus.mem_wdata_ready = 1'b0;
        end
        bus.victim_dirty = 1'b0;
        acceptCmd(32'h0000_0040, 1'b0);
        driveBurst(16'h000F, 4, 32'h0000_0040, 32'h0000_1000);
        checkDone();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
